// File: rtl/spi_byte_bridge_if.sv
// spi_byte_bridge_if: bundles the bridge's TX/RX byte streams, FIFO levels and
// the single-byte SPI master handshake.
//   slave  modport: bridge side (consumes tx stream and master status, drives
//                   rx stream, levels and the master launch signals)
//   master modport: environment side (producer/consumer and SPI master)
// Optional feature: defining SPI_BRIDGE_XFER_CNT_EN adds xfer_count[15:0].
interface spi_byte_bridge_if #(
    parameter int unsigned DEPTH_LOG2 = 3
);
    localparam int unsigned LW = DEPTH_LOG2 + 1;

    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          spi_start;
    logic [7:0]    spi_tx_byte;
    logic          spi_busy;
    logic [7:0]    spi_rx_byte;
`ifdef SPI_BRIDGE_XFER_CNT_EN
    logic [15:0]   xfer_count;

    modport slave (
        input  tx_data, tx_valid, rx_ready, spi_busy, spi_rx_byte,
        output tx_ready, rx_data, rx_valid, tx_level, rx_level,
        output spi_start, spi_tx_byte, xfer_count
    );

    modport master (
        output tx_data, tx_valid, rx_ready, spi_busy, spi_rx_byte,
        input  tx_ready, rx_data, rx_valid, tx_level, rx_level,
        input  spi_start, spi_tx_byte, xfer_count
    );
`else
    modport slave (
        input  tx_data, tx_valid, rx_ready, spi_busy, spi_rx_byte,
        output tx_ready, rx_data, rx_valid, tx_level, rx_level,
        output spi_start, spi_tx_byte
    );

    modport master (
        output tx_data, tx_valid, rx_ready, spi_busy, spi_rx_byte,
        input  tx_ready, rx_data, rx_valid, tx_level, rx_level,
        input  spi_start, spi_tx_byte
    );
`endif
endinterface

// File: rtl/spi_byte_bridge.sv
// spi_byte_bridge: stream-to-SPI byte bridge. Transmit bytes enter a TX FIFO,
// each byte launches one single-byte SPI master transfer, and each received
// byte is stored in an RX FIFO read out as a first-word fall-through stream.
// A launch is only issued while the RX FIFO has room, so no received byte is
// ever dropped.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - spi_byte_bridge_if.slave: tx stream (tx_data/valid/ready),
//            rx stream (rx_data/valid/ready), tx_level/rx_level,
//            master handshake (spi_start, spi_tx_byte, spi_busy, spi_rx_byte)
// Optional feature: defining SPI_BRIDGE_XFER_CNT_EN adds xfer_count[15:0],
// a wrapping count of received bytes pushed into the RX FIFO.
module spi_byte_bridge #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             reset,
    spi_byte_bridge_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_wptr_d;
    logic [PW-1:0] tx_rptr_q, tx_rptr_d;
    logic [LW-1:0] tx_cnt_q, tx_cnt_d;

    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_wptr_d;
    logic [PW-1:0] rx_rptr_q, rx_rptr_d;
    logic [LW-1:0] rx_cnt_q, rx_cnt_d;

    logic          spi_start_q, spi_start_d;
    logic [7:0]    spi_tx_byte_q, spi_tx_byte_d;

    logic          tx_pop_c;
    logic          rx_push_c;
    logic          tx_push_c;
    logic          rx_pop_c;
    logic          tx_ready_c;
    logic          rx_valid_c;
    logic          can_launch_c;

    // Status derived from registered state only; no path from tx_valid/rx_ready.
    // A full TX FIFO still accepts a byte in the cycle a launch pops its head,
    // so push and pop on the same edge both take effect.
    assign tx_ready_c   = (tx_cnt_q != LW'(DEPTH)) || tx_pop_c;
    assign rx_valid_c   = (rx_cnt_q != '0);
    assign tx_push_c    = bus.tx_valid && tx_ready_c;
    assign rx_pop_c     = rx_valid_c && bus.rx_ready;
    // RX space is reserved for the single in-flight byte before launching.
    assign can_launch_c = (tx_cnt_q != '0) && !bus.spi_busy && (rx_cnt_q < LW'(DEPTH));

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (can_launch_c) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (bus.spi_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.spi_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs: TX pop and launch in LAUNCH, RX push when the master finishes
    always_comb begin
        tx_pop_c      = 1'b0;
        rx_push_c     = 1'b0;
        spi_start_d   = 1'b0;
        spi_tx_byte_d = spi_tx_byte_q;
        case (state_q)
            LAUNCH: begin
                tx_pop_c      = 1'b1;
                spi_start_d   = 1'b1;
                spi_tx_byte_d = tx_mem_q[tx_rptr_q];
            end
            WAIT_DONE: rx_push_c = !bus.spi_busy;
            default: ;
        endcase
    end

    // FIFO next state
    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;

        if (tx_push_c) begin
            tx_mem_d[tx_wptr_q] = bus.tx_data;
            tx_wptr_d           = tx_wptr_q + PW'(1);
        end
        if (tx_pop_c) begin
            tx_rptr_d = tx_rptr_q + PW'(1);
        end
        tx_cnt_d = tx_cnt_q + LW'(tx_push_c) - LW'(tx_pop_c);

        if (rx_push_c) begin
            rx_mem_d[rx_wptr_q] = bus.spi_rx_byte;
            rx_wptr_d           = rx_wptr_q + PW'(1);
        end
        if (rx_pop_c) begin
            rx_rptr_d = rx_rptr_q + PW'(1);
        end
        rx_cnt_d = rx_cnt_q + LW'(rx_push_c) - LW'(rx_pop_c);
    end

    // Datapath registers; storage is cleared so rx_data reads 0x00 after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_mem_q      <= '{default: '0};
            tx_wptr_q     <= '0;
            tx_rptr_q     <= '0;
            tx_cnt_q      <= '0;
            rx_mem_q      <= '{default: '0};
            rx_wptr_q     <= '0;
            rx_rptr_q     <= '0;
            rx_cnt_q      <= '0;
            spi_start_q   <= 1'b0;
            spi_tx_byte_q <= '0;
        end else begin
            tx_mem_q      <= tx_mem_d;
            tx_wptr_q     <= tx_wptr_d;
            tx_rptr_q     <= tx_rptr_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_mem_q      <= rx_mem_d;
            rx_wptr_q     <= rx_wptr_d;
            rx_rptr_q     <= rx_rptr_d;
            rx_cnt_q      <= rx_cnt_d;
            spi_start_q   <= spi_start_d;
            spi_tx_byte_q <= spi_tx_byte_d;
        end
    end

`ifdef SPI_BRIDGE_XFER_CNT_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    // Wrapping count of bytes pushed into the RX FIFO
    always_comb begin
        xfer_count_d = xfer_count_q + 16'(rx_push_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.xfer_count = xfer_count_q;
`endif

    assign bus.tx_ready    = tx_ready_c;
    assign bus.rx_valid    = rx_valid_c;
    assign bus.rx_data     = rx_mem_q[rx_rptr_q];
    assign bus.tx_level    = tx_cnt_q;
    assign bus.rx_level    = rx_cnt_q;
    assign bus.spi_start   = spi_start_q;
    assign bus.spi_tx_byte = spi_tx_byte_q;

endmodule

// File: doc/spi_byte_bridge.md
# spi_byte_bridge

Stream-to-SPI byte bridge sitting directly upstream of the single-byte SPI master. Accepts transmit bytes on a valid/ready stream into a TX FIFO and launches one master transfer per byte. Captures each received byte into an RX FIFO presented as a valid/ready stream. Applies backpressure so no received byte is ever lost.

## Interface
- DEPTH_LOG2, default 3: log2 of each FIFO depth; DEPTH = 2**DEPTH_LOG2 entries per FIFO.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  TX FIFO not full; byte accepted on clk edge when tx_valid && tx_ready.
- rx_data  output  8  head of RX FIFO (first-word fall-through).
- rx_valid  output  1  RX FIFO not empty.
- rx_ready  input  1  consumer pops head on edge when rx_valid && rx_ready.
- tx_level  output  DEPTH_LOG2+1  TX FIFO occupancy.
- rx_level  output  DEPTH_LOG2+1  RX FIFO occupancy.
- spi_start  output  1  one-cycle launch pulse to master.
- spi_tx_byte  output  8  byte for master; registered, held until next launch.
- spi_busy  input  1  master busy.
- spi_rx_byte  input  8  master received byte; valid when spi_busy falls.

## Operation
- Reset values: tx_ready 1, rx_valid 0, rx_data 0x00, tx_level 0, rx_level 0, spi_start 0, spi_tx_byte 0x00; FIFOs emptied, pointers 0, FSM in IDLE.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE -> LAUNCH when tx_level != 0, spi_busy == 0, and rx_level < DEPTH (room reserved for the in-flight byte).
- LAUNCH: pop TX head into spi_tx_byte, spi_start = 1 for this cycle only; -> WAIT_BUSY.
- WAIT_BUSY: spi_start = 0; -> WAIT_DONE when spi_busy == 1.
- WAIT_DONE: when spi_busy == 0, push spi_rx_byte into RX FIFO; -> IDLE.
- Byte ordering: strict FIFO order for both directions; the Nth transmitted byte pairs with the Nth received byte.
- RX FIFO can never overflow: launch is gated on free space and only one transfer is ever in flight.
- FIFO rules: push when full is blocked (tx_ready = 0); simultaneous push and pop on the same FIFO are both honoured, level unchanged, including when full or empty (pop-empty never occurs, since valid gates it).
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH; levels are DEPTH_LOG2+1 bits, range 0..DEPTH.
- Reset mid-transfer: FSM returns to IDLE and FIFOs clear. The IDLE launch guard (spi_busy == 0) prevents launching while a master transfer started before reset is still running. That transfer's rx byte is discarded.

## Timing
- Byte written into empty TX FIFO of an idle bridge at edge k: tx_level = 1 after k. IDLE -> LAUNCH at edge k+1. spi_start high for cycle k+2..k+3 only.
- Launch edge to master busy: one clock (master samples start and sets busy).
- Edge where spi_busy is seen low in WAIT_DONE: rx_valid and rx_level update after that same edge; the next launch is possible two edges later.
- Per-byte overhead beyond the master's own transfer time: 4 clocks.
- tx_ready, rx_valid, and levels are combinational from registered pointers; no combinational path from tx_valid to tx_ready or from rx_ready to rx_valid.

## Configuration
- SPI_BRIDGE_XFER_CNT_EN:
  - Defined: adds output xfer_count [15:0]. It is reset to 0 and increments on each RX push, wrapping 0xFFFF -> 0x0000.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Single byte: after reset, push 0xA5 with the slave model returning 0x3C. Required: exactly one spi_start pulse, spi_tx_byte = 0xA5, then rx_data = 0x3C with rx_valid = 1 and rx_level = 1.
- Burst: push 0x01..0x08 back to back (DEPTH_LOG2 = 3) with the slave echoing the bitwise inverse. Required: tx_ready drops when tx_level = 8, and rx_data pops in order 0xFE..0xF7.
- Backpressure: rx_ready held 0 while pushing 12 bytes. Required: exactly 8 launches, then rx_level = 8 with no further spi_start. After draining with rx_ready = 1, the remaining 4 transfers complete in order.
- Simultaneous push/pop: with TX full, assert tx_valid on the same edge a launch pops. Required: tx_level stays 8 and no byte is lost or duplicated.
- Reset mid-transfer: pulse reset while in WAIT_DONE with 3 bytes queued. Required: all outputs return to reset values, and no spi_start occurs until spi_busy = 0.
- With SPI_BRIDGE_XFER_CNT_EN defined: 65537 transfers. Required: xfer_count = 0x0001.
